// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier sharing the pipeline ALU adder.
// Produces the low WIDTH bits of src1_i * src2_i after exactly WIDTH RUN cycles.
module mul_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       ALU_operation_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              accept_c;
  logic [WIDTH-1:0]  acc_sum_c;

  // A new request is only taken when no flush accompanies it.
  assign accept_c  = start_i & ~flush_i;
  // Partial-product accumulation; carries past WIDTH are dropped.
  assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update: accept, iterate WIDTH times, publish result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          mcand_d  = src1_i;
          mplier_d = src2_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_sum_c;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = acc_sum_c;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode the state register; stall is held low while in reset.
  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign result_o        = result_q;
  assign ALU_operation_o = (state_q == RUN) ? ALU_ADD : 4'b0000;
  assign stall_o         = rst_i & ((state_q == RUN) | accept_c);

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
- REQ-001: Parameter WIDTH, default 32, operand and result width in bits.
- REQ-002: Parameter ALU_ADD, default 4'b0010, ALU operation code driven while the shared adder is in use.
- REQ-003: clk_i  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
- REQ-005: start_i  input  1  multiply request from the EX stage.
- REQ-006: flush_i  input  1  pipeline flush; aborts any operation in progress.
- REQ-007: src1_i  input  WIDTH  multiplicand.
- REQ-008: src2_i  input  WIDTH  multiplier.
- REQ-009: busy_o  output  1  high while in RUN.
- REQ-010: stall_o  output  1  pipeline stall request (combinational).
- REQ-011: done_o  output  1  one-cycle completion pulse.
- REQ-012: result_o  output  WIDTH  low WIDTH bits of the product.
- REQ-013: ALU_operation_o  output  4  op code to the shared ALU: ALU_ADD in RUN, 4'b0000 otherwise.

Function
- REQ-014: FSM states: IDLE, RUN, DONE; encoding is free.
- REQ-015: IDLE: start_i=1 and flush_i=0 at the edge -> latch mcand=src1_i, mplier=src2_i, acc=0, cnt=0, go RUN.
- REQ-016: IDLE with start_i=0 or flush_i=1 -> stay IDLE, no register changes.
- REQ-017: RUN, each edge: if mplier[0]=1 then acc <= acc+mcand mod 2^WIDTH; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
- REQ-018: RUN lasts exactly WIDTH edges; no early termination on a zero multiplier.
- REQ-019: On the WIDTH-th RUN edge, result_o <= final acc and go DONE.
- REQ-020: DONE: done_o=1 for that single cycle; next edge goes to RUN if start_i=1 and flush_i=0 (REQ-015 latching), else to IDLE.
- REQ-021: Latency: done_o is high in the cycle after the WIDTH-th edge following the accepting edge (WIDTH+1 cycles after accept).
- REQ-022: stall_o = (state==RUN) or (state in {IDLE,DONE} and start_i=1 and flush_i=0).
- REQ-023: start_i in RUN is ignored; operands are not re-latched.
- REQ-024: flush_i=1 in RUN -> IDLE at the next edge; done_o stays 0; result_o unchanged.
- REQ-025: flush_i and start_i both high in IDLE or DONE -> flush wins; no operation is accepted.
- REQ-026: result_o holds its value until the next successful completion.
- REQ-027: Arithmetic is unsigned; overflow bits beyond WIDTH are discarded.

Reset
- REQ-028: rst_i=0 asynchronously forces IDLE, with acc, mcand, mplier, cnt and result_o all 0.
- REQ-029: During reset busy_o=0, done_o=0, ALU_operation_o=4'b0000; stall_o=0 regardless of start_i.
- REQ-030: Reset asserted mid-RUN abandons the operation with no done_o pulse; the first accept is possible at the first edge after rst_i=1.

Verification
- REQ-031: src1=7, src2=6, 1-cycle start -> busy_o high for 32 cycles, done_o pulse 33 cycles after accept, result_o=42.
- REQ-032: src1=0xFFFFFFFF, src2=2 -> result_o=0xFFFFFFFE; src1=0x80000000, src2=2 -> result_o=0.
- REQ-033: Start 5x3, assert flush_i on the 10th RUN cycle -> IDLE next cycle, no done_o, result_o keeps its prior value.
- REQ-034: Start 5x3, change src1/src2 and pulse start_i mid-RUN -> result_o=15, exactly one done_o pulse.
- REQ-035: Start 3x4, hold start_i with 9x9 in DONE -> result 12 then 81 with no IDLE cycle between; stall_o continuously high.
- REQ-036: Drop rst_i to 0 mid-RUN -> all outputs 0 immediately; after release, 2x2 yields result_o=4.
